// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Video timing and pixel-source block for a DVI transmitter. It runs
// horizontal/vertical counters for any resolution, requests pixels from an
// external frame source (RGB565 or RGB888), or substitutes built-in test
// patterns. Enable and mode are sampled only at the frame origin, so a frame
// is never torn.
//
// Ports:
//   pixel_clk    in   pixel clock
//   sys_rst      in   asynchronous reset, active-high
//   video_en     in   output enable (frame-latched)
//   mode         in   0 external, 1 colour bars, 2 grid, 3 solid (frame-latched)
//   pixel_data   in   source pixel, valid the cycle after data_req
//   data_req     out  pixel request (stage 1)
//   pixel_xpos   out  active-relative column of the requested pixel
//   pixel_ypos   out  active-relative line of the requested pixel
//   video_hs     out  horizontal sync (stage 2)
//   video_vs     out  vertical sync (stage 2)
//   video_de     out  data enable (stage 2)
//   video_rgb    out  {R8,G8,B8}, zero outside data enable (stage 2)
//   frame_start  out  one-cycle pulse at the aligned frame origin (stage 2)
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int          H_ACTIVE  = 1280,
  parameter int          H_FP      = 110,
  parameter int          H_SYNC    = 40,
  parameter int          H_BP      = 220,
  parameter int          V_ACTIVE  = 720,
  parameter int          V_FP      = 5,
  parameter int          V_SYNC    = 5,
  parameter int          V_BP      = 20,
  parameter bit          SYNC_POL  = 1'b1,
  parameter int          DATA_W    = 16,
  parameter logic [23:0] SOLID_RGB = 24'hFFFFFF
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              video_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic [10:0]       pixel_xpos,
  output logic [10:0]       pixel_ypos,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [23:0]       video_rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYN_E = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_S = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_E = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYN_E = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_E = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Counters and frame-latched controls
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        started_q;
  logic        en_q, en_d;
  mode_e       mode_q, mode_d;

  // Stage 1: request side
  logic        req_q, req_d;
  logic [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
  mode_e       mode1_q;

  // Middle stage: waits while the source answers the request
  logic        dem_q, hsm_q, vsm_q, fsm_q, extm_q;
  logic [23:0] patm_q, pat_d;

  // Stage 2: sink side
  logic        de_q, hs_q, vs_q, fs_q;
  logic [23:0] rgb_q, rgb_d;

  logic        frame_origin, h_act, v_act, act;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb, src_rgb;

  // NOTE: every signal written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    // The first origin after reset is skipped so en_q stays 0 for one frame.
    frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    en_d         = en_q;
    mode_d       = mode_q;
    if (frame_origin && started_q) begin
      en_d   = video_en;
      mode_d = mode_e'(mode);
    end

    h_act  = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_act  = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    act    = h_act && v_act;
    de1_d  = en_q && act;
    req_d  = de1_d && (mode_q == MODE_EXT);
    xpos_d = act ? h_cnt_q - H_ACT_S : '0;
    ypos_d = act ? v_cnt_q - V_ACT_S : '0;
    hs1_d  = (h_cnt_q < H_SYN_E) ? SYNC_POL : ~SYNC_POL;
    vs1_d  = (v_cnt_q < V_SYN_E) ? SYNC_POL : ~SYNC_POL;
    fs1_d  = frame_origin;
  end

  // Test patterns are computed from the stage-1 position one cycle ahead of
  // the sink stage, the same slot in which an external pixel arrives.
  always_comb begin
    bar_idx = 3'(xpos_q / 11'(BAR_W));
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pat_d = '0;
    unique case (mode1_q)
      MODE_BARS:  pat_d = bar_rgb;
      MODE_GRID:  pat_d = ((xpos_q[3:0] == 4'd0) || (ypos_q[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      MODE_SOLID: pat_d = SOLID_RGB;
      default:    pat_d = '0;
    endcase
  end

  // RGB565 is widened by replicating the top bits into the vacated LSBs.
  if (DATA_W == 16) begin : g_rgb565
    assign src_rgb = {pixel_data[15:11], pixel_data[15:13],
                      pixel_data[10:5],  pixel_data[10:9],
                      pixel_data[4:0],   pixel_data[4:2]};
  end else begin : g_rgb888
    assign src_rgb = pixel_data[23:0];
  end

  always_comb begin
    rgb_d = '0;
    if (dem_q) rgb_d = extm_q ? src_rgb : patm_q;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, keeping the pipeline in step.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      started_q <= 1'b0;
      en_q      <= 1'b0;
      mode_q    <= MODE_EXT;
      req_q     <= 1'b0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      de1_q     <= 1'b0;
      hs1_q     <= ~SYNC_POL;
      vs1_q     <= ~SYNC_POL;
      fs1_q     <= 1'b0;
      mode1_q   <= MODE_EXT;
      dem_q     <= 1'b0;
      hsm_q     <= ~SYNC_POL;
      vsm_q     <= ~SYNC_POL;
      fsm_q     <= 1'b0;
      extm_q    <= 1'b0;
      patm_q    <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      started_q <= 1'b1;
      en_q      <= en_d;
      mode_q    <= mode_d;
      req_q     <= req_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      de1_q     <= de1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      fs1_q     <= fs1_d;
      mode1_q   <= mode_q;
      dem_q     <= de1_q;
      hsm_q     <= hs1_q;
      vsm_q     <= vs1_q;
      fsm_q     <= fs1_q;
      extm_q    <= (mode1_q == MODE_EXT);
      patm_q    <= pat_d;
      de_q      <= dem_q;
      hs_q      <= hsm_q;
      vs_q      <= vsm_q;
      fs_q      <= fsm_q;
      rgb_q     <= rgb_d;
    end
  end

  assign data_req    = req_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Self-checking bench for video_timing_gen with a 16x4 active raster
// (22 x 7 total). A source model answers data_req one cycle later and pushes
// the expected expanded colour to a scoreboard popped on video_de. Pattern and
// expansion results are checked against a table of {mode, source, x, y, rgb}.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic        video_en;
  logic [1:0]  mode;
  logic [15:0] pixel_data = '0;
  logic        data_req;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .DATA_W(16), .SOLID_RGB(24'hFFFFFF)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .video_en   (video_en),
    .mode       (mode),
    .pixel_data (pixel_data),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .video_hs   (video_hs),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .video_rgb  (video_rgb),
    .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [15:0] src_pix(input logic [10:0] x, input logic [10:0] y);
    return (({5'b0, y} * 16'd1031) ^ ({5'b0, x} * 16'd4099) ^ 16'h5A3C);
  endfunction

  // Source / monitor state
  logic        src_const_en = 1'b0;
  logic [15:0] src_const    = '0;
  logic [15:0] nxt_data     = '0;
  logic        lag_chk      = 1'b0;
  logic [23:0] sb[$];
  logic [23:0] cap[64];
  logic [23:0] done_cap[64];
  int          req_idx = 0, de_idx = 0, last_reqs = 0, last_des = 0;
  int          cyc = 0;
  int          hs_rise = 0, vs_rise = 0;
  int          hs_period = 0, hs_width = 0, vs_period = 0, vs_width = 0;
  logic        hs_seen = 1'b0, vs_seen = 1'b0;
  logic        hs_prev = 1'b0, vs_prev = 1'b0, r1 = 1'b0, r2 = 1'b0;

  // Source drives the answer just after the edge following the request.
  initial forever begin
    @(posedge pixel_clk);
    #1 pixel_data = nxt_data;
  end

  always @(negedge pixel_clk) begin
    if (sys_rst) begin
      sb.delete();
      req_idx = 0; de_idx = 0;
      hs_seen = 1'b0; vs_seen = 1'b0; hs_prev = 1'b0; vs_prev = 1'b0;
      r1 = 1'b0; r2 = 1'b0;
      nxt_data = '0;
    end else begin
      logic [15:0] d;
      cyc++;
      if (lag_chk) check("de_lag", {31'b0, video_de}, {31'b0, r2});
      r2 = r1;
      r1 = data_req;
      if (!video_de) check("rgb_blank", {8'b0, video_rgb}, 32'h0);
      if (data_req) begin
        check("req_x", {21'b0, pixel_xpos}, 32'(req_idx % 16));
        check("req_y", {21'b0, pixel_ypos}, 32'(req_idx / 16));
        d = src_const_en ? src_const : src_pix(pixel_xpos, pixel_ypos);
        nxt_data = d;
        sb.push_back(exp565(d));
        req_idx++;
      end else begin
        nxt_data = 16'($urandom);
      end
      if (video_de) begin
        if (sb.size() > 0) check("rgb_ext", {8'b0, video_rgb}, {8'b0, sb.pop_front()});
        if (de_idx < 64) cap[de_idx] = video_rgb;
        de_idx++;
      end
      if (video_hs && !hs_prev) begin
        if (hs_seen) hs_period = cyc - hs_rise;
        hs_rise = cyc; hs_seen = 1'b1;
      end
      if (!video_hs && hs_prev) hs_width = cyc - hs_rise;
      if (video_vs && !vs_prev) begin
        if (vs_seen) vs_period = cyc - vs_rise;
        vs_rise = cyc; vs_seen = 1'b1;
      end
      if (!video_vs && vs_prev) vs_width = cyc - vs_rise;
      if (frame_start) begin
        check("fs_align", {29'b0, video_hs, video_vs, vs_prev}, 32'b110);
        last_reqs = req_idx;
        last_des  = de_idx;
        done_cap  = cap;
        req_idx   = 0;
        de_idx    = 0;
      end
      hs_prev = video_hs;
      vs_prev = video_vs;
    end
  end

  // Waits for the next frame_start (bounded), then one more negedge so the
  // monitor's per-frame snapshot is settled.
  task automatic wait_fs(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pixel_clk);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_fs_timeout"}, 32'd0, 32'd1);
    @(negedge pixel_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, data_req}, 32'd0);
    check({tag, "_x"},   {21'b0, pixel_xpos}, 32'd0);
    check({tag, "_y"},   {21'b0, pixel_ypos}, 32'd0);
    check({tag, "_hs"},  {31'b0, video_hs}, 32'd0);
    check({tag, "_vs"},  {31'b0, video_vs}, 32'd0);
    check({tag, "_de"},  {31'b0, video_de}, 32'd0);
    check({tag, "_rgb"}, {8'b0, video_rgb}, 32'd0);
    check({tag, "_fs"},  {31'b0, frame_start}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] src;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int   prev_mode;
    int   prev_src;
    logic seen;

    tbl[0]  = '{2'd0, 16'hF81F, 0,  0, 24'hFF00FF};
    tbl[1]  = '{2'd0, 16'hF81F, 15, 3, 24'hFF00FF};
    tbl[2]  = '{2'd0, 16'h0841, 7,  2, 24'h080808};
    tbl[3]  = '{2'd1, 16'h0000, 0,  0, 24'hFFFFFF};
    tbl[4]  = '{2'd1, 16'h0000, 1,  3, 24'hFFFFFF};
    tbl[5]  = '{2'd1, 16'h0000, 2,  0, 24'hFFFF00};
    tbl[6]  = '{2'd1, 16'h0000, 3,  1, 24'hFFFF00};
    tbl[7]  = '{2'd1, 16'h0000, 4,  2, 24'h00FFFF};
    tbl[8]  = '{2'd1, 16'h0000, 10, 1, 24'hFF0000};
    tbl[9]  = '{2'd1, 16'h0000, 14, 0, 24'h000000};
    tbl[10] = '{2'd1, 16'h0000, 15, 3, 24'h000000};
    tbl[11] = '{2'd2, 16'h0000, 0,  1, 24'hFFFFFF};
    tbl[12] = '{2'd2, 16'h0000, 5,  0, 24'hFFFFFF};
    tbl[13] = '{2'd2, 16'h0000, 5,  3, 24'h000000};
    tbl[14] = '{2'd3, 16'h0000, 9,  2, 24'hFFFFFF};

    sys_rst  = 1'b1;
    video_en = 1'b1;
    mode     = 2'd0;
    repeat (3) @(negedge pixel_clk);
    check_reset_outputs("rst");

    // Timing: one blank frame, then full external frames.
    sys_rst = 1'b0;
    lag_chk = 1'b1;
    wait_fs("t0");
    wait_fs("t1");
    check("frame0_reqs", 32'(last_reqs), 32'd0);
    wait_fs("t2");
    check("frame1_reqs", 32'(last_reqs), 32'd64);
    check("frame1_des",  32'(last_des),  32'd64);
    wait_fs("t3");
    check("frame2_reqs", 32'(last_reqs), 32'd64);
    check("hs_period", 32'(hs_period), 32'd22);
    check("hs_width",  32'(hs_width),  32'd2);
    check("vs_period", 32'(vs_period), 32'd154);
    check("vs_width",  32'(vs_width),  32'd22);
    lag_chk = 1'b0;

    // Table: expansion and test patterns, one captured frame per setting.
    prev_mode = -1;
    prev_src  = -1;
    for (int i = 0; i < 15; i++) begin
      if (int'(tbl[i].mode) != prev_mode || int'(tbl[i].src) != prev_src) begin
        mode         = tbl[i].mode;
        src_const    = tbl[i].src;
        src_const_en = (tbl[i].mode == 2'd0);
        wait_fs("v_a");
        wait_fs("v_b");
        wait_fs("v_c");
        check($sformatf("vec%0d_reqs", i), 32'(last_reqs), (tbl[i].mode == 2'd0) ? 32'd64 : 32'd0);
        check($sformatf("vec%0d_des", i),  32'(last_des),  32'd64);
        prev_mode = int'(tbl[i].mode);
        prev_src  = int'(tbl[i].src);
      end
      check($sformatf("vec%0d_rgb", i), {8'b0, done_cap[tbl[i].y * 16 + tbl[i].x]}, {8'b0, tbl[i].exp});
    end
    src_const_en = 1'b0;

    // Mid-frame mode change at v_cnt = 5 of a colour-bar frame.
    mode = 2'd1;
    wait_fs("m0");
    wait_fs("m1");
    repeat (108) @(negedge pixel_clk);
    mode = 2'd3;
    wait_fs("m2");
    check("mid_cur_x2y3", {8'b0, done_cap[3 * 16 + 2]}, 32'hFFFF00);
    check("mid_cur_x14y3", {8'b0, done_cap[3 * 16 + 14]}, 32'h000000);
    wait_fs("m3");
    check("mid_next_x0y0", {8'b0, done_cap[0]}, 32'hFFFFFF);
    check("mid_next_x2y0", {8'b0, done_cap[2]}, 32'hFFFFFF);
    check("mid_next_x14y3", {8'b0, done_cap[3 * 16 + 14]}, 32'hFFFFFF);

    // Disable mid-frame: current frame completes, next is blank but timed.
    mode = 2'd0;
    wait_fs("d0");
    wait_fs("d1");
    repeat (50) @(negedge pixel_clk);
    video_en = 1'b0;
    wait_fs("d2");
    check("dis_cur_reqs", 32'(last_reqs), 32'd64);
    check("dis_cur_des",  32'(last_des),  32'd64);
    wait_fs("d3");
    check("dis_next_reqs", 32'(last_reqs), 32'd0);
    check("dis_next_des",  32'(last_des),  32'd0);
    check("dis_hs_period", 32'(hs_period), 32'd22);
    check("dis_vs_period", 32'(vs_period), 32'd154);

    // Reset in the middle of an active line.
    video_en = 1'b1;
    wait_fs("r0");
    wait_fs("r1");
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixel_clk);
      if (data_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_find_req", {31'b0, seen}, 32'd1);
    repeat (3) @(negedge pixel_clk);
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge pixel_clk);
    sys_rst = 1'b0;
    wait_fs("r2");
    wait_fs("r3");
    check("post_rst_frame0_reqs", 32'(last_reqs), 32'd0);
    wait_fs("r4");
    check("post_rst_frame1_reqs", 32'(last_reqs), 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
